i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//
// I2C target (slave) that answers to one 7-bit address. It does no clock
// stretching: scl is only ever observed. On a write transfer every received
// byte is presented on outData with a one-cycle dataValid pulse, and every
// byte is ACKed. On a read transfer the block asks for each byte with a
// one-cycle dataReq pulse, then shifts that byte out MSB first. It keeps
// serving bytes until the master NACKs.
//
// All logic runs on inClock. The bus lines are first passed through 2-flop
// synchronizers, so inClock must be at least 8x the SCL rate.
//
// Ports
//   inClock   : system clock, rising edge
//   rst       : asynchronous active-low reset
//   scl       : bus clock input
//   sda       : bus data, open drain (driven 1'b0 or released to 1'bz)
//   inData    : byte to transmit; sampled on the scl falling edge after dataReq
//   dataReq   : one-cycle pulse requesting the next inData byte
//   outData   : last complete byte received on a write transfer
//   dataValid : one-cycle pulse when outData is updated
//   busy      : high from address ACK until STOP, NACK or address mismatch
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_target #(
    parameter logic [6:0] ADDR = 7'h1A
) (
    input  logic       inClock,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] inData,
    output logic       dataReq,
    output logic [7:0] outData,
    output logic       dataValid,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_t;

    // Synchronizer chains plus one extra stage of history for edge detection.
    // They reset to 1 because that is the idle level of both bus lines.
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    state_t     state_q,      state_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [6:0] rx_q,         rx_d;       // first 7 bits of the byte being received
    logic       rw_q,         rw_d;
    logic [7:0] tx_q,         tx_d;
    logic       sda_oe_q,     sda_oe_d;   // 1 = pull sda low
    logic       got_ack_q,    got_ack_d;  // master ACK seen in READ_ACK
    logic [7:0] out_data_q,   out_data_d;
    logic       data_valid_q, data_valid_d;
    logic       data_req_q,   data_req_d;
    logic       busy_q,       busy_d;

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  =  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q &  scl_prev_q;
    // START/STOP need scl high in both samples so an scl edge arriving in the
    // same clock as an sda edge is never mistaken for a bus condition.
    assign start_det = scl_sync_q & scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q &  sda_sync_q;

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        rw_d         = rw_q;
        tx_d         = tx_q;
        sda_oe_d     = sda_oe_q;
        got_ack_d    = got_ack_q;
        out_data_d   = out_data_q;
        data_valid_d = 1'b0;
        data_req_d   = 1'b0;
        busy_d       = busy_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
            got_ack_d = 1'b0;
        end else if (start_det) begin
            // Repeated start: busy is left alone until the address decision.
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            got_ack_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[5:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // rx_q holds the 7 address bits, the bit on the
                            // wire now is R/W.
                            rw_d = sda_sync_q;
                            if (rx_q == ADDR) begin
                                state_d    = ST_ADDR_ACK;
                                busy_d     = 1'b1;
                                data_req_d = sda_sync_q;
                            end else begin
                                state_d  = ST_IGNORE;
                                busy_d   = 1'b0;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                // Both ACK states enter with sda released. The first scl fall
                // starts the ACK and the second ends it, so sda_oe_q itself
                // tells the two falls apart.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (rw_q) begin
                                tx_d = inData;
                            end
                        end else if (rw_q) begin
                            state_d  = ST_READ;
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end else begin
                            state_d  = ST_WRITE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                ST_WRITE: begin
                    if (scl_rise) begin
                        rx_d      = {rx_q[5:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            out_data_d   = {rx_q, sda_sync_q};
                            data_valid_d = 1'b1;
                            state_d      = ST_WRITE_ACK;
                        end
                    end
                end

                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WRITE;
                        end
                    end
                end

                // Bit 7 is already on the wire when READ is entered. The falls
                // inside READ put out bits 6..0.
                ST_READ: begin
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_READ_ACK;
                        end
                    end
                end

                ST_READ_ACK: begin
                    if (scl_fall) begin
                        if (got_ack_q) begin
                            // This fall follows the dataReq pulse, so inData
                            // already holds the next byte.
                            state_d   = ST_READ;
                            got_ack_d = 1'b0;
                            sda_oe_d  = ~inData[7];
                            tx_d      = {inData[6:0], 1'b0};
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_rise) begin
                        if (!sda_sync_q) begin
                            got_ack_d  = 1'b1;
                            data_req_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end

                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments, so every flop samples
    // values from before the clock edge no matter what order the lines are in.
    always_ff @(posedge inClock or negedge rst) begin
        if (!rst) begin
            scl_meta_q   <= 1'b1;
            scl_sync_q   <= 1'b1;
            scl_prev_q   <= 1'b1;
            sda_meta_q   <= 1'b1;
            sda_sync_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 7'd0;
            rw_q         <= 1'b0;
            tx_q         <= 8'd0;
            sda_oe_q     <= 1'b0;
            got_ack_q    <= 1'b0;
            out_data_q   <= 8'h00;
            data_valid_q <= 1'b0;
            data_req_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            scl_meta_q   <= scl;
            scl_sync_q   <= scl_meta_q;
            scl_prev_q   <= scl_sync_q;
            sda_meta_q   <= sda;
            sda_sync_q   <= sda_meta_q;
            sda_prev_q   <= sda_sync_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            rw_q         <= rw_d;
            tx_q         <= tx_d;
            sda_oe_q     <= sda_oe_d;
            got_ack_q    <= got_ack_d;
            out_data_q   <= out_data_d;
            data_valid_q <= data_valid_d;
            data_req_q   <= data_req_d;
            busy_q       <= busy_d;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign dataReq   = data_req_q;
    assign outData   = out_data_q;
    assign dataValid = data_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
//
// A behavioural I2C master drives scl and an open-drain sda with a pullup.
// The stimulus pushes expected write bytes and expected read bytes into
// queues. A monitor on the falling system-clock edge pops and compares them
// whenever the DUT pulses dataValid or the master finishes reading a byte.
// The monitor also answers dataReq from a queue of bytes to transmit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_target;

    localparam int Q = 50;  // quarter of an SCL period (SCL = 20 system clocks)

    logic       inClock   = 1'b0;
    logic       rst       = 1'b0;
    logic       scl_m     = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] inData    = 8'h00;
    wire        sda_w;
    logic       dataReq, dataValid, busy;
    logic [7:0] outData;

    assign sda_w = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 inClock = ~inClock;

    i2c_target #(.ADDR(7'h1A)) dut (
        .inClock  (inClock),
        .rst      (rst),
        .scl      (scl_m),
        .sda      (sda_w),
        .inData   (inData),
        .dataReq  (dataReq),
        .outData  (outData),
        .dataValid(dataValid),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_wr[$];  // bytes expected on outData, in order
    logic [7:0] exp_rd[$];  // bytes expected to be read off sda
    logic [7:0] rd_obs[$];  // bytes the master actually read
    logic [7:0] rd_src[$];  // bytes handed to inData on each dataReq

    int dv_cnt      = 0;
    int req_cnt     = 0;
    int dut_low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge inClock) begin
        if (dataValid) begin
            dv_cnt++;
            if (exp_wr.size() == 0) check("unexpected_dataValid", 32'(dataValid), 32'd0);
            else                    check("outData", 32'(outData), 32'(exp_wr.pop_front()));
        end
        if (dataReq) begin
            req_cnt++;
            if (rd_src.size() > 0) inData = rd_src.pop_front();
            else                   check("unexpected_dataReq", 32'(dataReq), 32'd0);
        end
        while (rd_obs.size() > 0) begin
            if (exp_rd.size() == 0) check("unexpected_read_byte", 32'(rd_obs.pop_front()), 32'hFFFF_FFFF);
            else                    check("read_byte", 32'(rd_obs.pop_front()), 32'(exp_rd.pop_front()));
        end
        if (rst && sda_w == 1'b0 && !m_sda_low) dut_low_cnt++;
    end

    // ---------------- master primitives ----------------
    task automatic m_start();
        if (!scl_m) begin
            #Q m_sda_low = 1'b0;
            #Q scl_m = 1'b1;
        end
        #Q m_sda_low = 1'b1;
        #Q scl_m = 1'b0;
    endtask

    task automatic m_stop();
        #Q m_sda_low = 1'b1;
        #Q scl_m = 1'b1;
        #Q m_sda_low = 1'b0;
        #(4*Q);
    endtask

    task automatic write_bit(input logic b);
        #Q m_sda_low = ~b;
        #Q scl_m = 1'b1;
        #(2*Q) scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        #Q m_sda_low = 1'b0;
        #Q scl_m = 1'b1;
        #Q b = sda_w;
        #Q scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack);
        logic [7:0] d;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        rd_obs.push_back(d);
        write_bit(master_ack);
    endtask

    task automatic clear_counts();
        dv_cnt      = 0;
        req_cnt     = 0;
        dut_low_cnt = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1);
    end

    initial begin
        logic ack;
        logic b;

        // ---- reset state ----
        #23;
        check("reset_dataReq",   32'(dataReq),   32'd0);
        check("reset_dataValid", 32'(dataValid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_outData",   32'(outData),   32'd0);
        check("reset_sda",       32'(sda_w),     32'd1);
        rst = 1'b1;
        #100;

        // ---- write 0xA5 to address 0x1A ----
        clear_counts();
        m_start();
        write_byte(8'h34, ack);
        check("wr_addr_ack", 32'(ack), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        exp_wr.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'd0);
        m_stop();
        check("wr_dv_cycles", 32'(dv_cnt), 32'd1);
        check("wr_busy_after_stop", 32'(busy), 32'd0);
        check("wr_outData", 32'(outData), 32'hA5);

        // ---- address mismatch ----
        clear_counts();
        m_start();
        write_byte(8'h36, ack);
        check("mm_addr_nack", 32'(ack), 32'd1);
        check("mm_busy", 32'(busy), 32'd0);
        write_byte(8'hFF, ack);
        check("mm_data_nack", 32'(ack), 32'd1);
        m_stop();
        check("mm_dut_sda_low", 32'(dut_low_cnt), 32'd0);
        check("mm_dv_cycles", 32'(dv_cnt), 32'd0);

        // ---- read two bytes, ACK then NACK ----
        clear_counts();
        rd_src.push_back(8'h3C);
        rd_src.push_back(8'hC3);
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        m_start();
        write_byte(8'h35, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0);
        read_byte(1'b1);
        check("rd_busy_after_nack", 32'(busy), 32'd0);
        m_stop();
        check("rd_req_cycles", 32'(req_cnt), 32'd2);
        check("rd_sda_released", 32'(sda_w), 32'd1);

        // ---- write then repeated start into read ----
        clear_counts();
        exp_wr.push_back(8'h11);
        rd_src.push_back(8'h5A);
        m_start();
        write_byte(8'h34, ack);
        check("rs_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h11, ack);
        check("rs_data_ack", 32'(ack), 32'd0);
        m_start();
        check("rs_busy_held", 32'(busy), 32'd1);
        write_byte(8'h35, ack);
        check("rs_addr2_ack", 32'(ack), 32'd0);
        exp_rd.push_back(8'h5A);
        read_byte(1'b1);
        m_stop();
        check("rs_outData", 32'(outData), 32'h11);
        check("rs_req_cycles", 32'(req_cnt), 32'd1);

        // ---- STOP after 4 bits of a write byte ----
        clear_counts();
        m_start();
        write_byte(8'h34, ack);
        check("ab_addr_ack", 32'(ack), 32'd0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        m_stop();
        check("ab_outData", 32'(outData), 32'h11);
        check("ab_dv_cycles", 32'(dv_cnt), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_sda_released", 32'(sda_w), 32'd1);

        // ---- reset asserted while the target drives a 0 ----
        clear_counts();
        rd_src.push_back(8'h00);
        m_start();
        write_byte(8'h35, ack);
        check("rst_addr_ack", 32'(ack), 32'd0);
        read_bit(b);
        check("rst_read_bit7", 32'(b), 32'd0);
        read_bit(b);
        check("rst_read_bit6", 32'(b), 32'd0);
        #Q;
        check("rst_sda_driven", 32'(sda_w), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_sda_released", 32'(sda_w), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_dataReq",   32'(dataReq),   32'd0);
        check("rst_dataValid", 32'(dataValid), 32'd0);
        check("rst_outData",   32'(outData),   32'd0);
        #40 rst = 1'b1;
        // Bits on the bus before a fresh START must be ignored.
        write_bit(1'b0);
        m_stop();
        exp_wr.push_back(8'h5C);
        m_start();
        write_byte(8'h34, ack);
        check("post_rst_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h5C, ack);
        check("post_rst_data_ack", 32'(ack), 32'd0);
        m_stop();
        check("post_rst_outData", 32'(outData), 32'h5C);

        // ---- scoreboard drained ----
        #100;
        check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
        check("rd_src_left", 32'(rd_src.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
